btn_sw_conditioner: RTL
=======================

Name: btn_sw_conditioner

Overview:
Front-end input conditioner between the board pins (btn[4:0], sw[7:0]) and FSM_Controller. It synchronises every input to clk and debounces each channel independently. It produces per-button level, press, release and long-press one-shot pulses, plus a debounced switch bus with a change strobe. The FSM consumes the single-cycle pulses instead of raw button levels, so each physical press counts exactly once.

Parameters:
- N_BTN, 5, number of button channels.
- N_SW, 8, number of switch channels.
- DEB_CYCLES, 500000, consecutive stable samples required to accept a new level (20 ms at 25 MHz); must be >= 2.
- LONG_CYCLES, 25000000, debounced-high cycles before long-press fires (1 s at 25 MHz); must be > DEB_CYCLES.

Ports:
- clk  input  1  system clock (25 MHz divided clock).
- rst  input  1  synchronous reset, active-high.
- i_btn  input  N_BTN  raw asynchronous button pins.
- i_sw  input  N_SW  raw asynchronous switch pins.
- o_btn_level  output  N_BTN  debounced button level.
- o_btn_press  output  N_BTN  1-cycle pulse on debounced 0->1.
- o_btn_release  output  N_BTN  1-cycle pulse on debounced 1->0.
- o_btn_long  output  N_BTN  1-cycle pulse once per hold reaching LONG_CYCLES.
- o_sw_stable  output  N_SW  debounced switch bus.
- o_sw_changed  output  1  1-cycle pulse when any o_sw_stable bit changes.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all synchroniser flops, counters, levels and pulses go to 0 on the clk edge with rst=1. All outputs read 0 in the cycle after that edge. Reset mid-debounce or mid-hold discards partial counts.
- Synchroniser: 2-flop chain per channel (sync2). No logic is placed between the two flops.
- Debounce, per channel, identical for buttons and switches:
  - If sync2 == level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEB_CYCLES-1 and sync2 != level: level <= sync2 and the counter clears.
  - Result: a clean pin edge appears on level exactly 2 + DEB_CYCLES clk edges later.
  - Any glitch shorter than DEB_CYCLES samples produces no change.
  - Counter width is clog2(DEB_CYCLES); it never wraps.
- Pulses: press/release are registered. Each is high in exactly the cycle where o_btn_level first shows the new value, and low otherwise.
- Long-press, per button, with hold counter width clog2(LONG_CYCLES+1):
  - States: IDLE (level=0), HOLD (counting), FIRED (saturated).
  - IDLE->HOLD on press. HOLD counts each cycle level=1.
  - When count reaches LONG_CYCLES: o_btn_long pulses for 1 cycle and the channel enters FIRED.
  - FIRED holds with no further pulses.
  - Any state->IDLE on release, with the counter cleared. The release pulse still fires after a long press.
- Switch change: o_sw_changed is high in the cycle o_sw_stable differs from its previous value. Simultaneous multi-bit changes give one pulse. Changes on consecutive cycles give consecutive pulses.
- Simultaneous events: channels are fully independent. Several press/release/long pulses may assert in the same cycle.
- A button held through reset deassertion is seen as a new press: level rises and press pulses 2 + DEB_CYCLES cycles after rst falls.
- No combinational path from any input to any output.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=16):
1. Reset: rst=1 for 3 cycles with i_btn=5'h1F, i_sw=8'hA5 -> all outputs 0 during reset. After rst falls, o_btn_level=5'h1F, o_btn_press=5'h1F (one cycle only) and o_sw_stable=8'hA5, o_sw_changed=1, all 6 cycles later.
2. Bounce: i_btn[0] toggles 1,0,1,0,1 on successive cycles, then holds 1 -> level rises exactly 6 cycles after the final 0->1. Exactly one o_btn_press[0] pulse; no release pulse.
3. Glitch reject: i_btn[2]=1 for 3 cycles then 0 -> o_btn_level[2] and o_btn_press[2] stay 0 throughout.
4. Long press: hold i_btn[1]=1 for 40 cycles after debounce -> o_btn_long[1] pulses once, 16 cycles after o_btn_press[1], with no repeat. On release, o_btn_release[1] pulses 6 cycles after the pin falls. A repeat press held for 10 cycles gives no long pulse.
5. Switches: i_sw 8'h00 -> 8'h3C (all bits together) -> one o_sw_changed pulse, with o_sw_stable=8'h3C after 6 cycles. Single-bit bounce on sw[7] shorter than 4 cycles -> no change.
6. Concurrency and reset mid-hold: btn[3] and btn[4] pressed in the same cycle -> both press bits assert in the same cycle. Assert rst at hold count 10 -> o_btn_long never fires. After reset, still-held buttons re-press 6 cycles later.

Source files
------------

// File: rtl/btn_sw_conditioner.sv
// Input conditioner: 2-flop synchroniser plus per-channel debounce for buttons and switches,
// with press/release/long-press one-shots and a switch-bus change strobe.
module btn_sw_conditioner #(
    parameter int N_BTN       = 5,
    parameter int N_SW        = 8,
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [N_SW-1:0]  i_sw,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release,
    output logic [N_BTN-1:0] o_btn_long,
    output logic [N_SW-1:0]  o_sw_stable,
    output logic             o_sw_changed
);

    localparam int N_CH   = N_BTN + N_SW;
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    // Buttons occupy the low channels, switches the high channels.
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] flip;

    logic [N_BTN-1:0] press_reg;
    logic [N_BTN-1:0] release_reg;
    logic [N_BTN-1:0] long_pulse;
    logic             sw_changed_reg;

    assign raw_in = {i_sw, i_btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_deb
            logic [DEB_W-1:0] cnt_reg;
            logic             level_reg;

            // flip marks the cycle in which the level register takes the new value
            assign flip[gi]  = (sync2_reg[gi] != level_reg) && (cnt_reg == DEB_W'(DEB_CYCLES - 1));
            assign level[gi] = level_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                    level_reg <= sync2_reg[gi];
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DEB_W'(1);
                end
            end
        end

        for (gi = 0; gi < N_BTN; gi++) begin : g_long
            logic [1:0]        state_reg;
            logic [HOLD_W-1:0] hold_reg;
            logic              long_reg;

            assign long_pulse[gi] = long_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                    hold_reg  <= '0;
                    long_reg  <= 1'b0;
                end else begin
                    long_reg <= 1'b0;
                    if (!level[gi]) begin
                        state_reg <= ST_IDLE;
                        hold_reg  <= '0;
                    end else begin
                        case (state_reg)
                            ST_IDLE: begin
                                // first cycle with the level visible counts as hold cycle 1
                                state_reg <= ST_HOLD;
                                hold_reg  <= HOLD_W'(1);
                            end
                            ST_HOLD: begin
                                if (hold_reg == HOLD_W'(LONG_CYCLES - 1)) begin
                                    long_reg  <= 1'b1;
                                    state_reg <= ST_FIRED;
                                    hold_reg  <= HOLD_W'(LONG_CYCLES);
                                end else begin
                                    hold_reg <= hold_reg + HOLD_W'(1);
                                end
                            end
                            ST_FIRED: begin
                                state_reg <= ST_FIRED;
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                                hold_reg  <= '0;
                            end
                        endcase
                    end
                end
            end
        end
    endgenerate

    // Pulses are registered alongside the level update so they coincide with the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_reg      <= '0;
            release_reg    <= '0;
            sw_changed_reg <= 1'b0;
        end else begin
            press_reg      <= flip[N_BTN-1:0] & sync2_reg[N_BTN-1:0];
            release_reg    <= flip[N_BTN-1:0] & ~sync2_reg[N_BTN-1:0];
            sw_changed_reg <= |flip[N_CH-1:N_BTN];
        end
    end

    assign o_btn_level   = level[N_BTN-1:0];
    assign o_btn_press   = press_reg;
    assign o_btn_release = release_reg;
    assign o_btn_long    = long_pulse;
    assign o_sw_stable   = level[N_CH-1:N_BTN];
    assign o_sw_changed  = sw_changed_reg;

endmodule
